// File: rtl/cnna_mul_pipe_param.sv
// -----------------------------------------------------------------------------
// cnna_mul_pipe_param
//
// Parametrised, pipelined fixed-point multiplier for the CNN accelerator
// datapath. Computes the exact product of din0 and din1, optionally adds a
// half-LSB rounding constant, arithmetically right-shifts by SHIFT and then
// either saturates or wraps into OUT_WIDTH bits. An overflow flag travels with
// every result, and a sticky overflow flag collects overflows of transferred
// results until it is cleared.
//
// Ports
//   ap_clk      in   clock, rising edge
//   ap_rst_n    in   asynchronous active-low reset
//   in_valid    in   input sample valid
//   in_ready    out  input accepted when in_valid && in_ready
//   din0        in   operand A, A_WIDTH bits (signed if A_SIGNED)
//   din1        in   operand B, B_WIDTH bits (signed if B_SIGNED)
//   out_valid   out  result valid
//   out_ready   in   downstream accepts result
//   dout        out  result, OUT_WIDTH bits
//   ovf         out  overflow flag aligned with dout
//   ovf_sticky  out  OR of ovf over all transferred results since reset/clear
//   ovf_clr     in   synchronous clear of ovf_sticky (a same-cycle set wins)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid must keep its data stable until the transfer.
// Here the whole pipeline shares one enable, en = !out_valid || out_ready, and
// in_ready equals en; while out_valid && !out_ready every stage holds, so dout
// and ovf stay stable. Bubbles are carried through, never compressed.
//
// Pipeline structure
//   NUM_STAGE == 1 : multiply, round, shift and saturate all feed the single
//                    output register (in_ready then depends combinationally
//                    on out_ready).
//   NUM_STAGE >= 2 : the exact product is registered in stage 1 and carried
//                    through NUM_STAGE-2 further product registers (retiming
//                    room for the multiplier); round/shift/saturate sits in
//                    front of the output register.
// -----------------------------------------------------------------------------
module cnna_mul_pipe_param #(
  parameter int A_WIDTH   = 26,
  parameter int B_WIDTH   = 15,
  parameter int A_SIGNED  = 1,
  parameter int B_SIGNED  = 0,
  parameter int OUT_WIDTH = 32,
  parameter int NUM_STAGE = 3,
  parameter int SHIFT     = 0,
  parameter int ROUND     = 0,
  parameter int SAT       = 0
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   din0,
  input  logic [B_WIDTH-1:0]   din1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 ovf,
  output logic                 ovf_sticky,
  input  logic                 ovf_clr
);

  // Working width of the exact product: one bit more than A+B so that both
  // signed and unsigned operands fit as signed values.
  localparam int PW = A_WIDTH + B_WIDTH + 1;

  localparam bit RES_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);

  // Half-LSB rounding constant; RSH keeps the shift amount legal when
  // SHIFT is zero (the constant is then forced to zero anyway).
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [PW:0] RND_ADD = ((ROUND != 0) && (SHIFT > 0)) ?
                                    ({{PW{1'b0}}, 1'b1} << RSH) : '0;

  // Signed saturation bounds, built by shifting so OUT_WIDTH == 1 also works.
  localparam logic [OUT_WIDTH-1:0] S_MIN = {{(OUT_WIDTH-1){1'b0}}, 1'b1} << (OUT_WIDTH - 1);
  localparam logic [OUT_WIDTH-1:0] S_MAX = ~S_MIN;

  // ---------------------------------------------------------------------------
  // Global enable
  // ---------------------------------------------------------------------------
  logic en;
  logic out_valid_q;
  logic [OUT_WIDTH-1:0] dout_q;
  logic ovf_q;
  logic sticky_q;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // ---------------------------------------------------------------------------
  // Operand extension and exact product
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;

  always_comb begin
    if (A_SIGNED != 0) begin
      a_ext = {{(PW-A_WIDTH){din0[A_WIDTH-1]}}, din0};
    end else begin
      a_ext = {{(PW-A_WIDTH){1'b0}}, din0};
    end
    if (B_SIGNED != 0) begin
      b_ext = {{(PW-B_WIDTH){din1[B_WIDTH-1]}}, din1};
    end else begin
      b_ext = {{(PW-B_WIDTH){1'b0}}, din1};
    end
  end

  // The product of the extended operands never exceeds PW signed bits, so the
  // truncation to PW bits is exact.
  assign prod = a_ext * b_ext;

  // ---------------------------------------------------------------------------
  // Product pipeline (stages 1 .. NUM_STAGE-1)
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] tail_p;
  logic                 tail_v;

  if (NUM_STAGE == 1) begin : g_direct
    assign tail_p = prod;
    assign tail_v = in_valid;
  end else begin : g_pipe
    logic signed [PW-1:0]  p_q [NUM_STAGE-1];
    logic [NUM_STAGE-2:0]  v_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        v_q <= '0;
        for (int k = 0; k < NUM_STAGE - 1; k++) begin
          p_q[k] <= '0;
        end
      end else if (en) begin
        v_q[0] <= in_valid;
        p_q[0] <= prod;
        for (int k = 1; k < NUM_STAGE - 1; k++) begin
          v_q[k] <= v_q[k-1];
          p_q[k] <= p_q[k-1];
        end
      end
    end

    assign tail_p = p_q[NUM_STAGE-2];
    assign tail_v = v_q[NUM_STAGE-2];
  end

  // ---------------------------------------------------------------------------
  // Round, shift, range check
  // ---------------------------------------------------------------------------
  // One extra bit of headroom: an unsigned near-full-scale product plus the
  // rounding constant can exceed PW signed bits.
  logic signed [PW:0] rsum;
  logic signed [PW:0] shifted;
  logic               fits;
  logic [OUT_WIDTH-1:0] clamp;

  assign rsum    = {tail_p[PW-1], tail_p} + RND_ADD;
  assign shifted = rsum >>> SHIFT;

  if (RES_SIGNED) begin : g_res_signed
    // Representable iff every bit from the result sign bit upwards is a copy
    // of the sign.
    logic [PW-OUT_WIDTH+1:0] upper;
    assign upper = shifted[PW:OUT_WIDTH-1];
    assign fits  = (upper == '0) || (upper == '1);
    assign clamp = shifted[PW] ? S_MIN : S_MAX;
  end else begin : g_res_unsigned
    // Unsigned operands give a non-negative product, so only the upper bits
    // being zero matters, and clamping always goes to full scale.
    logic [PW-OUT_WIDTH:0] upper;
    assign upper = shifted[PW:OUT_WIDTH];
    assign fits  = (upper == '0);
    assign clamp = '1;
  end

  logic [OUT_WIDTH-1:0] post_d;
  logic                 post_ovf;

  always_comb begin
    post_ovf = !fits;
    if ((SAT != 0) && !fits) begin
      post_d = clamp;
    end else begin
      post_d = shifted[OUT_WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage (stage NUM_STAGE)
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else if (en) begin
      out_valid_q <= tail_v;
      dout_q      <= post_d;
      // Bubbles never carry an overflow indication.
      ovf_q       <= tail_v && post_ovf;
    end
  end

  // Sticky overflow: a transfer of an overflowing result beats a clear.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sticky_q <= 1'b0;
    end else if (out_valid_q && out_ready && ovf_q) begin
      sticky_q <= 1'b1;
    end else if (ovf_clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign dout       = dout_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_cnna_mul_pipe_param.sv
// -----------------------------------------------------------------------------
// tb_cnna_mul_pipe_param
//
// Three multiplier instances share one stimulus stream: the default wrapping
// configuration, a saturating one, and one with SHIFT=4 / ROUND=1. A
// behavioural model computes each expected result from plain integer
// arithmetic; a monitor pushes expectations on every accepted sample and
// compares every transferred result, the in_ready rule and stall stability.
// Directed sections pin literal values and latency.
// -----------------------------------------------------------------------------
module tb_cnna_mul_pipe_param;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        ovf_clr = 1'b0;
  logic [25:0] din0 = '0;
  logic [14:0] din1 = '0;

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic        of0, of1, of2;
  logic        st0, st1, st2;
  logic [31:0] d0, d1, d2;

  cnna_mul_pipe_param u_def (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .din0(din0), .din1(din1), .out_valid(ov0), .out_ready(out_ready),
    .dout(d0), .ovf(of0), .ovf_sticky(st0), .ovf_clr(ovf_clr)
  );

  cnna_mul_pipe_param #(.SAT(1)) u_sat (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .din0(din0), .din1(din1), .out_valid(ov1), .out_ready(out_ready),
    .dout(d1), .ovf(of1), .ovf_sticky(st1), .ovf_clr(ovf_clr)
  );

  cnna_mul_pipe_param #(.SHIFT(4), .ROUND(1)) u_rnd (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .din0(din0), .din1(din1), .out_valid(ov2), .out_ready(out_ready),
    .dout(d2), .ovf(of2), .ovf_sticky(st2), .ovf_clr(ovf_clr)
  );

  logic [2:0]  rdy_a, ov_a, of_a, st_a;
  logic [31:0] d_a [3];
  assign rdy_a = {rdy2, rdy1, rdy0};
  assign ov_a  = {ov2, ov1, ov0};
  assign of_a  = {of2, of1, of0};
  assign st_a  = {st2, st1, st0};
  always_comb begin
    d_a[0] = d0;
    d_a[1] = d1;
    d_a[2] = d2;
  end

  int cfg_shift [3] = '{0, 0, 4};
  bit cfg_rnd   [3] = '{0, 0, 1};
  bit cfg_sat   [3] = '{0, 1, 0};

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: {ovf, dout} for instance k (A signed 26b, B unsigned
  // 15b, 32-bit result).
  // ---------------------------------------------------------------------------
  function automatic logic [32:0] model(input logic [25:0] a, input logic [14:0] b, input int k);
    longint av, bv, p, r, lo, hi;
    logic [63:0] rb;
    logic o;
    av = longint'(a);
    if (a[25]) av = av - (longint'(1) <<< 26);
    bv = longint'(b);
    p  = av * bv;
    if (cfg_rnd[k] && cfg_shift[k] > 0) p = p + (longint'(1) <<< (cfg_shift[k] - 1));
    r  = p >>> cfg_shift[k];
    lo = -(longint'(1) <<< 31);
    hi = (longint'(1) <<< 31) - 1;
    o  = (r < lo) || (r > hi);
    if (cfg_sat[k] && o) r = (r < lo) ? lo : hi;
    rb = r;
    return {o, rb[31:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard / monitor
  // ---------------------------------------------------------------------------
  logic [32:0] exp_q [3][$];
  logic [32:0] prev_val [3];
  bit          prev_stall [3];
  int          n_out [3] = '{0, 0, 0};

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) prev_stall[k] = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        logic [32:0] e;
        chk($sformatf("in_ready_rule[%0d]", k), rdy_a[k], !(ov_a[k] && !out_ready));
        if (prev_stall[k]) begin
          chk($sformatf("stall_valid_hold[%0d]", k), ov_a[k], 1);
          chk($sformatf("stall_data_hold[%0d]", k), {of_a[k], d_a[k]}, prev_val[k]);
        end
        if (in_valid && rdy_a[k]) exp_q[k].push_back(model(din0, din1, k));
        if (ov_a[k] && out_ready) begin
          chk($sformatf("out_has_expected[%0d]", k), exp_q[k].size() != 0, 1);
          if (exp_q[k].size() != 0) begin
            e = exp_q[k].pop_front();
            chk($sformatf("result[%0d]", k), {of_a[k], d_a[k]}, e);
          end
          n_out[k]++;
        end
        prev_stall[k] = ov_a[k] && !out_ready;
        prev_val[k]   = {of_a[k], d_a[k]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  logic [31:0] g_d [3];
  logic        g_o [3];

  // Present one sample and return just after the edge that accepted it.
  task automatic send(input logic [25:0] a, input logic [14:0] b);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    din0 = a;
    din1 = b;
    do begin
      @(negedge clk);
      acc = rdy0;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    chk("send_accepted", acc, 1);
  endtask

  // Wait for the next result (out_ready assumed high), capture all three
  // instances, optionally pulse ovf_clr in the transfer cycle.
  task automatic get_out(output int lat, input bit clr);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov0 && lat < 50);
    chk("out_valid_seen", ov0, 1);
    for (int k = 0; k < 3; k++) begin
      g_d[k] = d_a[k];
      g_o[k] = of_a[k];
    end
    if (clr) ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  bit stream_done = 1'b0;

  initial begin
    int lat;
    int base;

    // Pin the model against hand-computed values.
    chk("model_neg3x5",   model(26'h3FFFFFD, 15'd5, 0),      {1'b0, 32'hFFFFFFF1});
    chk("model_wrap",     model(26'h1FFFFFF, 15'h7FFF, 0),   {1'b1, 32'hFDFF8001});
    chk("model_sat_pos",  model(26'h1FFFFFF, 15'h7FFF, 1),   {1'b1, 32'h7FFFFFFF});
    chk("model_sat_neg",  model(26'h2000000, 15'h7FFF, 1),   {1'b1, 32'h80000000});
    chk("model_rnd_1x24", model(26'd1, 15'd24, 2),           {1'b0, 32'h00000002});
    chk("model_rnd_m1",   model(26'h3FFFFFF, 15'd24, 2),     {1'b0, 32'hFFFFFFFF});

    // Reset and initial state.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_out_valid[%0d]", k), ov_a[k], 0);
      chk($sformatf("rst_dout[%0d]", k), d_a[k], 0);
      chk($sformatf("rst_ovf[%0d]", k), of_a[k], 0);
      chk($sformatf("rst_sticky[%0d]", k), st_a[k], 0);
      chk($sformatf("rst_in_ready[%0d]", k), rdy_a[k], 1);
    end
    @(posedge clk);
    #1;

    // -3 * 5, latency and value.
    send(26'h3FFFFFD, 15'd5);
    in_valid = 1'b0;
    get_out(lat, 1'b0);
    chk("latency_first", lat, 3);
    chk("neg3x5_dout", g_d[0], 32'hFFFFFFF1);
    chk("neg3x5_ovf", g_o[0], 0);
    chk("neg3x5_rnd_dout", g_d[2], 32'hFFFFFFFF);

    // Wrap overflow, saturation, sticky.
    send(26'h1FFFFFF, 15'h7FFF);
    in_valid = 1'b0;
    get_out(lat, 1'b0);
    chk("wrap_dout", g_d[0], 32'hFDFF8001);
    chk("wrap_ovf", g_o[0], 1);
    chk("sat_pos_dout", g_d[1], 32'h7FFFFFFF);
    chk("sat_pos_ovf", g_o[1], 1);
    chk("rnd_wrap_dout", g_d[2], 32'hFFDFF800);
    chk("sticky_set", st0, 1);
    chk("sticky_set_sat", st1, 1);

    send(26'd2, 15'd3);
    in_valid = 1'b0;
    get_out(lat, 1'b1);
    chk("clr_sample_dout", g_d[0], 32'd6);
    chk("sticky_cleared", st0, 0);

    send(26'h1FFFFFF, 15'h7FFF);
    in_valid = 1'b0;
    get_out(lat, 1'b1);
    chk("sticky_set_wins", st0, 1);

    send(26'h2000000, 15'h7FFF);
    in_valid = 1'b0;
    get_out(lat, 1'b0);
    chk("neg_wrap_dout", g_d[0], 32'h02000000);
    chk("neg_wrap_ovf", g_o[0], 1);
    chk("sat_neg_dout", g_d[1], 32'h80000000);
    chk("sat_neg_ovf", g_o[1], 1);

    // Rounding cases, back to back.
    send(26'd1, 15'd24);
    send(26'h3FFFFFF, 15'd24);
    send(26'd1, 15'd23);
    in_valid = 1'b0;
    get_out(lat, 1'b0);
    chk("rnd_1x24", g_d[2], 32'd2);
    chk("rnd_1x24_ovf", g_o[2], 0);
    get_out(lat, 1'b0);
    chk("rnd_m1x24", g_d[2], 32'hFFFFFFFF);
    chk("rnd_m1x24_ovf", g_o[2], 0);
    get_out(lat, 1'b0);
    chk("rnd_1x23", g_d[2], 32'd1);
    chk("rnd_1x23_ovf", g_o[2], 0);

    // Stream with stalls.
    base = n_out[0];
    fork
      begin
        for (int i = 0; i < 20; i++) send(26'(i), 15'(i + 1));
        in_valid = 1'b0;
        stream_done = 1'b1;
      end
      begin
        for (int c = 0; c < 400; c++) begin
          if (stream_done && exp_q[0].size() == 0) break;
          if (c < 5) out_ready = 1'b1;
          else if (c <= 9) out_ready = 1'b0;
          else out_ready = ($urandom_range(0, 1) == 1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(5);
    chk("stream_drained", exp_q[0].size(), 0);
    chk("stream_count", n_out[0] - base, 20);

    // Reset with samples in flight.
    send(26'h1FFFFFF, 15'h7FFF);
    in_valid = 1'b0;
    get_out(lat, 1'b0);
    chk("pre_reset_sticky", st0, 1);
    send(26'd7, 15'd9);
    send(26'd100, 15'd3);
    send(26'h3FFFFFB, 15'd11);
    in_valid = 1'b0;
    chk("pre_reset_valid", ov0, 1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midrst_out_valid[%0d]", k), ov_a[k], 0);
      chk($sformatf("midrst_dout[%0d]", k), d_a[k], 0);
      chk($sformatf("midrst_sticky[%0d]", k), st_a[k], 0);
      exp_q[k].delete();
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("no_stale_out", ov0, 0);
    end
    @(posedge clk);
    #1;
    send(26'd3, 15'd4);
    in_valid = 1'b0;
    get_out(lat, 1'b0);
    chk("latency_after_reset", lat, 3);
    chk("after_reset_dout", g_d[0], 32'd12);
    idle(4);

    for (int k = 0; k < 3; k++) begin
      chk($sformatf("final_queue_empty[%0d]", k), exp_q[k].size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cnna_mul_pipe_param.md
Name: cnna_mul_pipe_param

Overview:
Parametrised, pipelined fixed-point multiplier for the CNN accelerator datapath. It replaces fixed-width single-cycle multiplier instances. Operand widths, signedness, latency, output width, post-shift, rounding and saturation are all configurable. It has a valid/ready stream interface with full-pipeline stall, and reports overflow per sample and sticky.

Parameters:
A_WIDTH, 26, din0 width
B_WIDTH, 15, din1 width
A_SIGNED, 1, 1 = din0 two's complement, 0 = unsigned
B_SIGNED, 0, 1 = din1 two's complement, 0 = unsigned
OUT_WIDTH, 32, dout width, 1..A_WIDTH+B_WIDTH
NUM_STAGE, 3, latency in cycles, >=1
SHIFT, 0, arithmetic right shift of full product, 0..A_WIDTH+B_WIDTH-1
ROUND, 0, 1 = add 2^(SHIFT-1) before shift (ignored when SHIFT=0)
SAT, 0, 1 = saturate to OUT_WIDTH, 0 = wrap (truncate)

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  input accepted when in_valid && in_ready
din0  in  A_WIDTH  operand A
din1  in  B_WIDTH  operand B
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
dout  out  OUT_WIDTH  result
ovf  out  1  overflow flag aligned with dout
ovf_sticky  out  1  OR of ovf over all transferred results since reset/clear
ovf_clr  in  1  synchronous clear of ovf_sticky

Behaviour:
- Reset (async assert, sync-released by system): all stage valid bits 0, out_valid=0, dout=0, ovf=0, ovf_sticky=0. in_ready=1 from the first cycle after reset. In-flight samples are discarded on reset mid-operation.
- Arithmetic, performed conceptually in PW = A_WIDTH+B_WIDTH+1 signed bits:
  - Sign-extend signed operands, zero-extend unsigned ones; form the exact product P.
  - R = (P + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT. Rounding is round-half-up, toward +inf.
  - Result is signed when A_SIGNED||B_SIGNED, otherwise unsigned.
  - SAT=1: clamp R to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] (signed) or [0, 2^OUT_WIDTH-1] (unsigned). ovf=1 iff clamped.
  - SAT=0: dout = R[OUT_WIDTH-1:0]. ovf=1 iff R is not representable, i.e. the discarded upper bits are not a sign/zero extension.
- Pipeline:
  - NUM_STAGE register stages, each holding valid, data and ovf. Multiplier/shift/saturate logic may be distributed across stages; only the end-to-end function is specified.
  - Global enable en = !out_valid || out_ready. in_ready = en.
  - When en=1 all stages advance by one. When en=0 all stages hold; bubbles are not compressed.
  - Latency: a sample accepted at cycle t appears with out_valid=1 at cycle t+NUM_STAGE if no stall occurred.
  - Throughput 1 sample/cycle. Order preserved. No loss or duplication under any out_ready pattern.
  - dout/ovf hold stable while out_valid && !out_ready.
  - in_valid=0 on an advancing cycle inserts a bubble.
- ovf_sticky:
  - Set on any cycle with out_valid && out_ready && ovf.
  - ovf_clr clears it on the next edge.
  - If set and clear occur in the same cycle, set wins.
- NUM_STAGE=1: single output register; in_ready combinationally depends on out_ready. This path is permitted.

Test Plan:
- Defaults: din0=0x3FFFFFD (-3), din1=5, out_ready=1 -> 3 cycles after accept: dout=0xFFFFFFF1, ovf=0.
- Defaults, wrap: din0=0x1FFFFFF, din1=0x7FFF -> dout=0xFDFF8001, ovf=1, ovf_sticky=1 after transfer. Assert ovf_clr together with a new non-overflowing result -> sticky=0; assert ovf_clr together with a new overflowing result -> sticky stays 1.
- SAT=1, same operands -> dout=0x7FFFFFFF, ovf=1. din0=0x2000000 (-2^25), din1=0x7FFF -> dout=0x80000000, ovf=1.
- SHIFT=4, ROUND=1: (1,24) -> dout=2; (-1,24) -> dout=0xFFFFFFFF (-1); (1,23) -> 1; ovf=0 throughout.
- Stream 20 back-to-back samples din0=i, din1=i+1. Hold out_ready=0 for cycles 5..9 and toggle it randomly afterwards -> in_ready low exactly when out_valid && !out_ready. Outputs are i*(i+1) in order, none lost or duplicated, and dout stable while stalled.
- Assert ap_rst_n low mid-stream with 3 samples in flight -> out_valid=0, dout=0, ovf_sticky=0 immediately. No stale result emerges after release. The first new sample appears NUM_STAGE cycles after it is accepted.
